// File: rtl/mult_result_store.sv
// Multiply datapath stage: fixed-latency shift-add multiplier feeding a small result RAM
// with a registered read port and a sticky refused-write flag.
module mult_result_store #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_adr,
  output logic               wr_drop,
  input  logic [AW-1:0]      rd_adr,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               rd_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [2*WIDTH-1:0] ram [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic               wr_in_range;
  logic               rd_in_range;

  assign busy        = (state != IDLE);
  assign wr_in_range = ({1'b0, wr_adr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_adr} < DEPTH_L);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add core: one multiplier bit per RUN cycle, product published in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        DONE: begin
          product <= acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM is small and must read back as cleared after reset, so it sits in
  // flops with async reset rather than a reset-less memory macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      valid    <= '0;
      wr_drop  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        if (!busy && wr_in_range) begin
          ram[wr_adr]   <= product;
          valid[wr_adr] <= 1'b1;
        end else begin
          wr_drop <= 1'b1;
        end
      end
      // Read samples pre-edge contents, so a colliding write shows up one cycle later.
      if (rd_in_range) begin
        rd_data  <= ram[rd_adr];
        rd_valid <= valid[rd_adr];
      end else begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_result_store.sv
// Self-checking bench for mult_result_store: directed scenarios plus randomized multiplies,
// compared against a plain arithmetic model of the product and the result RAM.
module tb_mult_result_store;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               start;
  logic               busy, done;
  logic [2*WIDTH-1:0] product;
  logic               wr_en;
  logic [AW-1:0]      wr_adr;
  logic               wr_drop;
  logic [AW-1:0]      rd_adr;
  logic [2*WIDTH-1:0] rd_data;
  logic               rd_valid;

  mult_result_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_a     (op_a),
    .op_b     (op_b),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .wr_en    (wr_en),
    .wr_adr   (wr_adr),
    .wr_drop  (wr_drop),
    .rd_adr   (rd_adr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: RAM contents, valid flags, last product, sticky drop.
  logic [2*WIDTH-1:0] m_ram [DEPTH];
  bit                 m_valid [DEPTH];
  logic [2*WIDTH-1:0] m_product;
  bit                 m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < DEPTH; i++) begin
      m_ram[i]   = '0;
      m_valid[i] = 1'b0;
    end
    m_product = '0;
    m_drop    = 1'b0;
  endtask

  // mode 0: plain; 1: start re-pulsed during RUN; 2: write attempt during RUN; 3: reset in RUN.
  task automatic do_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int mode);
    logic [2*WIDTH-1:0] exp_p;
    exp_p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
    for (int i = 1; i <= WIDTH + 1; i++) begin
      check("busy_in_run", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      check("product_hold", 32'(product), 32'(m_product));
      check("wr_drop_run", 32'(wr_drop), 32'(m_drop));
      if (mode == 1 && i == 3) begin
        op_a  = 8'd1;
        op_b  = 8'd1;
        start = 1'b1;
      end
      if (mode == 1 && i == 6) start = 1'b0;
      if (mode == 2 && i == 2) begin
        wr_en  = 1'b1;
        wr_adr = 3'd2;
        m_drop = 1'b1;
      end
      if (mode == 2 && i == 3) wr_en = 1'b0;
      if (mode == 3 && i == 4) begin
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_wr_drop", 32'(wr_drop), 32'd0);
        model_reset();
        tick();
        reset = 1'b0;
        for (int k = 0; k < WIDTH + 3; k++) begin
          tick();
          check("abort_no_done", 32'(done), 32'd0);
        end
        return;
      end
      tick();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("product", 32'(product), 32'(exp_p));
    m_product = exp_p;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("product_kept", 32'(product), 32'(m_product));
  endtask

  task automatic do_write(input int adr);
    wr_en  = 1'b1;
    wr_adr = AW'(adr);
    if (adr < DEPTH) begin
      m_ram[adr]   = m_product;
      m_valid[adr] = 1'b1;
    end else begin
      m_drop = 1'b1;
    end
    tick();
    wr_en = 1'b0;
    check("wr_drop", 32'(wr_drop), 32'(m_drop));
  endtask

  task automatic do_read(input int adr);
    rd_adr = AW'(adr);
    tick();
    check("rd_data", 32'(rd_data), (adr < DEPTH) ? 32'(m_ram[adr]) : 32'd0);
    check("rd_valid", 32'(rd_valid), (adr < DEPTH) ? 32'(m_valid[adr]) : 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    op_a   = '0;
    op_b   = '0;
    start  = 1'b0;
    wr_en  = 1'b0;
    wr_adr = '0;
    rd_adr = '0;
    model_reset();
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_wr_drop", 32'(wr_drop), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic multiply, store and read back.
    do_mult(8'd13, 8'd11, 0);
    do_write(5);
    do_read(5);
    do_read(4);

    // Extremes, back to back.
    do_mult(8'd255, 8'd255, 0);
    do_mult(8'd0, 8'd200, 0);

    // Restart attempt while busy is ignored; a single done pulse follows.
    do_mult(8'd13, 8'd11, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("single_done", 32'(done), 32'd0);
    end

    // Write during RUN is refused and sticky; ram[2] stays unwritten.
    do_mult(8'd9, 8'd9, 2);
    do_read(2);
    tick();
    check("wr_drop_sticky", 32'(wr_drop), 32'd1);

    // Same-cycle read and write of one address: old data first, new data next cycle.
    rd_adr = 3'd5;
    wr_en  = 1'b1;
    wr_adr = 3'd5;
    tick();
    wr_en = 1'b0;
    check("rw_old_data", 32'(rd_data), 32'(m_ram[5]));
    m_ram[5] = m_product;
    tick();
    check("rw_new_data", 32'(rd_data), 32'(m_ram[5]));

    // Reset during RUN aborts and clears everything.
    do_mult(8'd50, 8'd60, 3);
    for (int adr = 0; adr < DEPTH; adr++) do_read(adr);
    do_mult(8'd7, 8'd9, 0);

    // Randomized multiplies with interleaved stores and reads.
    for (int n = 0; n < 25; n++) begin
      do_mult(8'($urandom), 8'($urandom), 0);
      if ($urandom_range(0, 3) != 0) do_write(int'($urandom_range(0, DEPTH - 1)));
      do_read(int'($urandom_range(0, DEPTH - 1)));
    end
    for (int adr = 0; adr < DEPTH; adr++) do_read(adr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
